// File: rtl/seq_sll_unit.sv
// rtl/seq_sll_unit.sv - multi-cycle shift-left-logical functional unit
//
// Computes C = A << B[SHAMT_W-1:0] with zero fill, moving at most STEP bit
// positions per clock so the per-cycle shifter stays small.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   issue request, A/B valid
//   in_ready   unit idle and able to accept (low while rst is high)
//   A          operand to shift
//   B          shift source, only B[SHAMT_W-1:0] used
//   flush      synchronous cancel of any in-flight operation
//   out_valid  C holds a completed result
//   out_ready  consumer accepts C
//   C          registered result
//   busy       unit is not idle
module seq_sll_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] C,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // One bit wider than rem so STEP == WIDTH is representable.
    localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

    logic [1:0]         state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] rem;

    logic [WIDTH-1:0]   acc_step;
    logic [SHAMT_W-1:0] rem_step;

    // Only the low shift-amount bits of B matter.
    logic unused_b;
    assign unused_b = ^B[WIDTH-1:SHAMT_W];

    // Next acc/rem for one SHIFT cycle. The remainder case is a mux of
    // constant shifts below STEP rather than a full barrel shifter.
    always_comb begin
        acc_step = acc << STEP;
        rem_step = rem - STEP_W[SHAMT_W-1:0];
        if ({1'b0, rem} < STEP_W) begin
            acc_step = acc;
            rem_step = '0;
            for (int k = 1; k < STEP; k++) begin
                if (rem == SHAMT_W'(k)) begin
                    acc_step = acc << k;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
        end else if (flush) begin
            // acc/rem are left as they are; nothing observes them in IDLE.
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= A;
                        rem   <= B[SHAMT_W-1:0];
                        state <= (B[SHAMT_W-1:0] == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_step;
                    rem <= rem_step;
                    if (rem_step == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign C         = acc;

endmodule

// File: tb/tb_seq_sll_unit.sv
// tb/tb_seq_sll_unit.sv - self-checking bench for seq_sll_unit
module tb_seq_sll_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        iv   [3];
    logic        ordy [3];
    logic [31:0] a    [3];
    logic [31:0] b    [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        by   [3];
    logic [31:0] c    [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: STEP=4, instance 1: STEP=1, instance 2: STEP=32.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        seq_sll_unit #(
            .WIDTH  (32),
            .SHAMT_W(5),
            .STEP   (g == 0 ? 4 : (g == 1 ? 1 : 32))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .A        (a[g]),
            .B        (b[g]),
            .flush    (flush),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .C        (c[g]),
            .busy     (by[g])
        );
    end

    function automatic int steps_of(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op on instance d and check result, latency, hold and release.
    task automatic run_op(input int d, input logic [31:0] av, input logic [31:0] bv, input int hold);
        int          sh;
        int          lat;
        int          edges;
        logic [31:0] exp;
        sh    = int'(bv[4:0]);
        exp   = av << sh;
        lat   = 1 + (sh + steps_of(d) - 1) / steps_of(d);
        chk("in_ready_idle", 32'(ir[d]), 32'd1);
        iv[d] = 1'b1;
        a[d]  = av;
        b[d]  = bv;
        tick;
        iv[d] = 1'b0;
        a[d]  = $urandom;
        b[d]  = $urandom;
        edges = 1;
        while (ov[d] !== 1'b1 && edges < 200) begin
            chk("busy_shift", 32'(by[d]), 32'd1);
            chk("in_ready_busy", 32'(ir[d]), 32'd0);
            tick;
            edges++;
        end
        chk("latency", 32'(edges), 32'(lat));
        chk("result", c[d], exp);
        chk("in_ready_done", 32'(ir[d]), 32'd0);
        repeat (hold) begin
            tick;
            chk("hold_valid", 32'(ov[d]), 32'd1);
            chk("hold_c", c[d], exp);
        end
        ordy[d] = 1'b1;
        tick;
        ordy[d] = 1'b0;
        chk("post_valid", 32'(ov[d]), 32'd0);
        chk("post_busy", 32'(by[d]), 32'd0);
        chk("post_in_ready", 32'(ir[d]), 32'd1);
    endtask

    initial begin
        logic [31:0] rb;
        rst   = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i]   = 1'b0;
            ordy[i] = 1'b0;
            a[i]    = '0;
            b[i]    = '0;
        end
        tick;
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("rst_c", c[i], 32'd0);
            chk("rst_valid", 32'(ov[i]), 32'd0);
            chk("rst_busy", 32'(by[i]), 32'd0);
            chk("rst_in_ready", 32'(ir[i]), 32'd0);
        end
        rst = 1'b0;
        tick;
        chk("in_ready_after_rst", 32'(ir[0]), 32'd1);

        // Directed cases on the STEP=4 instance.
        run_op(0, 32'h0000_0001, 32'd31, 0);
        run_op(0, 32'hDEAD_BEEF, 32'd0, 0);
        run_op(0, 32'h1234_5678, 32'h0000_0024, 0);
        run_op(0, 32'hFFFF_FFFF, 32'd5, 4);
        chk("known_c_fffffff", c[0], 32'hFFFF_FFE0);

        // Flush during the third SHIFT cycle of shamt=31.
        iv[0] = 1'b1;
        a[0]  = 32'h1;
        b[0]  = 32'd31;
        tick;
        iv[0] = 1'b0;
        tick;
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_valid", 32'(ov[0]), 32'd0);
        chk("flush_busy", 32'(by[0]), 32'd0);
        chk("flush_in_ready", 32'(ir[0]), 32'd1);
        repeat (10) begin
            tick;
            chk("flush_no_valid", 32'(ov[0]), 32'd0);
        end
        run_op(0, 32'h3, 32'd2, 0);
        chk("after_flush_c", c[0], 32'hC);

        // Reset in the middle of a shift.
        iv[0] = 1'b1;
        a[0]  = 32'h1;
        b[0]  = 32'd31;
        tick;
        iv[0] = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk("midrst_c", c[0], 32'd0);
        chk("midrst_valid", 32'(ov[0]), 32'd0);
        chk("midrst_busy", 32'(by[0]), 32'd0);
        chk("midrst_in_ready", 32'(ir[0]), 32'd0);
        rst = 1'b0;
        tick;
        chk("midrst_in_ready_after", 32'(ir[0]), 32'd1);

        // flush wins over in_valid: no accept.
        iv[0] = 1'b1;
        a[0]  = 32'h5;
        b[0]  = 32'd7;
        flush = 1'b1;
        tick;
        iv[0] = 1'b0;
        flush = 1'b0;
        chk("flush_iv_busy", 32'(by[0]), 32'd0);
        chk("flush_iv_valid", 32'(ov[0]), 32'd0);
        chk("flush_iv_in_ready", 32'(ir[0]), 32'd1);
        tick;
        chk("flush_iv_busy2", 32'(by[0]), 32'd0);

        // Randomized sweep: every shamt on every STEP, random A and upper B bits.
        for (int d = 0; d < 3; d++) begin
            for (int s = 0; s < 32; s++) begin
                rb      = $urandom;
                rb[4:0] = 5'(s);
                run_op(d, $urandom, rb, int'($urandom_range(0, 2)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
